jtopl_pg_seq: RTL and testbench

- Slot scheduler for the phase-generator datapath: time-multiplexes one jtopl_pg_comb instance across all operator slots in a fixed round-robin.
- Each slot it fetches block/fnum/mul from the operator register file, drives the combinational phase-increment and phase-add datapath, and stores each slot's phase accumulator.
- It applies key-on phase resets and emits a per-slot 10-bit phase to the envelope/operator stage. It sits between the register file and the operator pipeline.

---
 rtl/jtopl_pg_seq.sv | 108 ++++++++++
 tb/tb_jtopl_pg_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_pg_seq.sv
// Phase-generator slot scheduler: walks all operator slots round-robin through one
// shared phase datapath, keeps each slot's phase accumulator and applies key-on resets.
module jtopl_pg_seq #(
  parameter int SLOTS = 18,
  parameter int PHW   = 20
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  output logic [4:0]     cfg_slot,
  input  logic [2:0]     cfg_block,
  input  logic [9:0]     cfg_fnum,
  input  logic [3:0]     cfg_mul,
  input  logic           keyon_req,
  input  logic [4:0]     keyon_slot,
  output logic [2:0]     pg_block,
  output logic [9:0]     pg_fnum,
  output logic [3:0]     pg_mul,
  output logic [16:0]    pg_phinc_in,
  output logic [PHW-1:0] pg_phase_in,
  output logic           pg_rst,
  input  logic [16:0]    pg_phinc_out,
  input  logic [PHW-1:0] pg_phase_out,
  input  logic [9:0]     pg_phase_op,
  output logic [4:0]     op_slot,
  output logic [9:0]     op_phase,
  output logic           op_valid,
  output logic           zero
);

  localparam logic [4:0] LAST = 5'(SLOTS - 1);

  logic [4:0]     cnt;
  logic [4:0]     slot1;
  logic [4:0]     slot2;
  logic           v1;
  logic           v2;
  logic [2:0]     blk1;
  logic [9:0]     fnum1;
  logic [3:0]     mul1;
  logic [3:0]     mul2;
  logic [16:0]    phinc2;
  logic [PHW-1:0] phase_mem [SLOTS];
  logic [SLOTS-1:0] pending;
  logic           keyon_hit;

  assign cfg_slot    = cnt;
  assign pg_block    = blk1;
  assign pg_fnum     = fnum1;
  assign pg_mul      = mul2;
  assign pg_phinc_in = phinc2;
  assign pg_phase_in = phase_mem[slot2];

  // A request arriving while its slot sits in stage 2 resets that slot right away.
  assign keyon_hit = keyon_req && (keyon_slot == slot2);
  assign pg_rst    = v2 && (pending[slot2] || keyon_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      zero     <= 1'b0;
      slot1    <= '0;
      v1       <= 1'b0;
      blk1     <= '0;
      fnum1    <= '0;
      mul1     <= '0;
      slot2    <= '0;
      v2       <= 1'b0;
      mul2     <= '0;
      phinc2   <= '0;
      op_slot  <= '0;
      op_phase <= '0;
      op_valid <= 1'b0;
    end else if (cen) begin
      cnt      <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
      zero     <= (cnt == 5'd0);
      slot1    <= cnt;
      v1       <= 1'b1;
      blk1     <= cfg_block;
      fnum1    <= cfg_fnum;
      mul1     <= cfg_mul;
      slot2    <= slot1;
      v2       <= v1;
      mul2     <= mul1;
      phinc2   <= pg_phinc_out;
      op_slot  <= slot2;
      op_phase <= pg_phase_op;
      op_valid <= v2;
    end
  end

  // Clearing the stage-2 slot is written last so a same-cycle request is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int i = 0; i < SLOTS; i++) phase_mem[i] <= '0;
    end else if (cen) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (keyon_req && keyon_slot == 5'(i)) pending[i] <= 1'b1;
      end
      if (v2) begin
        phase_mem[slot2] <= pg_phase_out;
        pending[slot2]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtopl_pg_seq.sv
// Bench for jtopl_pg_seq: behavioural register file and phase datapath around the DUT,
// with a scoreboard of per-slot operator phases predicted from a cen-count model.
module tb_jtopl_pg_seq;

  localparam int SLOTS = 18;
  localparam int PHW   = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cen;
  logic [4:0]     cfg_slot;
  logic [2:0]     cfg_block;
  logic [9:0]     cfg_fnum;
  logic [3:0]     cfg_mul;
  logic           keyon_req;
  logic [4:0]     keyon_slot;
  logic [2:0]     pg_block;
  logic [9:0]     pg_fnum;
  logic [3:0]     pg_mul;
  logic [16:0]    pg_phinc_in;
  logic [PHW-1:0] pg_phase_in;
  logic           pg_rst;
  logic [16:0]    pg_phinc_out;
  logic [PHW-1:0] pg_phase_out;
  logic [9:0]     pg_phase_op;
  logic [4:0]     op_slot;
  logic [9:0]     op_phase;
  logic           op_valid;
  logic           zero;

  jtopl_pg_seq #(.SLOTS(SLOTS), .PHW(PHW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cfg_slot(cfg_slot), .cfg_block(cfg_block), .cfg_fnum(cfg_fnum), .cfg_mul(cfg_mul),
    .keyon_req(keyon_req), .keyon_slot(keyon_slot),
    .pg_block(pg_block), .pg_fnum(pg_fnum), .pg_mul(pg_mul),
    .pg_phinc_in(pg_phinc_in), .pg_phase_in(pg_phase_in), .pg_rst(pg_rst),
    .pg_phinc_out(pg_phinc_out), .pg_phase_out(pg_phase_out), .pg_phase_op(pg_phase_op),
    .op_slot(op_slot), .op_phase(op_phase), .op_valid(op_valid), .zero(zero)
  );

  always #5 clk = ~clk;

  logic [2:0] tbl_blk  [SLOTS];
  logic [9:0] tbl_fnum [SLOTS];
  logic [3:0] tbl_mul  [SLOTS];

  assign cfg_block = (cfg_slot < SLOTS) ? tbl_blk[cfg_slot]  : 3'd0;
  assign cfg_fnum  = (cfg_slot < SLOTS) ? tbl_fnum[cfg_slot] : 10'd0;
  assign cfg_mul   = (cfg_slot < SLOTS) ? tbl_mul[cfg_slot]  : 4'd0;

  function automatic logic [16:0] phinc_f(input logic [2:0] b, input logic [9:0] f);
    logic [17:0] t;
    t = {8'd0, f} << b;
    return t[17:1];
  endfunction

  function automatic logic [PHW-1:0] step_f(input logic [16:0] p, input logic [3:0] m);
    logic [21:0] t;
    if (m == 4'd0) t = {5'd0, p} >> 1;
    else           t = {5'd0, p} * {18'd0, m};
    return t[PHW-1:0];
  endfunction

  always_comb begin
    pg_phinc_out = phinc_f(pg_block, pg_fnum);
    pg_phase_out = pg_rst ? '0 : pg_phase_in + step_f(pg_phinc_in, pg_mul);
    pg_phase_op  = pg_phase_out[PHW-1 -: 10];
  end

  typedef struct {
    logic [4:0] slot;
    logic [9:0] ph;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             m_n;
  int             cur_s2;
  logic [PHW-1:0] ref_phase [SLOTS];
  bit             ref_pend  [SLOTS];
  logic           exp_rst, obs_rst, exp_zero, exp_valid;

  // One clock; on cen cycles the model advances and the serviced slot's result is queued.
  task automatic cyc(input bit c, input bit kreq, input logic [4:0] ks);
    int s2;
    logic [PHW-1:0] newp;
    cen = c; keyon_req = kreq; keyon_slot = ks;
    #1;
    obs_rst = pg_rst;
    exp_rst = 1'b0;
    s2 = -1;
    if (c) begin
      if (m_n >= 2) begin
        s2 = (m_n - 2) % SLOTS;
        exp_rst = ref_pend[s2] || (kreq && int'(ks) == s2);
        newp = exp_rst ? '0 : ref_phase[s2] + step_f(phinc_f(tbl_blk[s2], tbl_fnum[s2]), tbl_mul[s2]);
        ref_phase[s2] = newp;
        ref_pend[s2] = 1'b0;
        sb.push_back('{slot: 5'(s2), ph: newp[PHW-1 -: 10]});
      end
      if (kreq && int'(ks) < SLOTS && int'(ks) != s2) ref_pend[ks] = 1'b1;
      exp_zero  = ((m_n % SLOTS) == 0);
      exp_valid = (m_n >= 2);
      m_n++;
    end
    cur_s2 = s2;
    @(posedge clk);
    @(negedge clk);
    cen = 1'b0; keyon_req = 1'b0;
  endtask

  task automatic model_clear();
    m_n = 0; sb.delete(); exp_zero = 1'b0; exp_valid = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin ref_phase[i] = '0; ref_pend[i] = 1'b0; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cen = 1'b0; keyon_req = 1'b0;
    repeat (2) @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; cen = 1'b1; keyon_req = 1'b0; keyon_slot = 5'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cfg_slot, pg_block, pg_fnum, pg_mul, pg_phinc_in, pg_phase_in, pg_rst,
         op_slot, op_phase, op_valid, zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: cfg_slot=%0d op_valid=%0b op_slot=%0d op_phase=%0d zero=%0b pg_phase_in=%0h, want all 0",
               cfg_slot, op_valid, op_slot, op_phase, zero, pg_phase_in);
    end
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * SLOTS + 3; i++) begin
      cyc(1'b1, 1'b0, 5'd0);
      checks++;
      if (cfg_slot !== 5'(m_n % SLOTS) || zero !== exp_zero || op_valid !== exp_valid) begin
        errors++;
        $display("FAIL seq cen%0d: cfg_slot=%0d zero=%0b op_valid=%0b, want %0d %0b %0b",
                 i + 1, cfg_slot, zero, op_valid, m_n % SLOTS, exp_zero, exp_valid);
      end
      if (i == 2) begin
        checks++;
        if (op_valid !== 1'b1 || op_slot !== 5'd0) begin
          errors++;
          $display("FAIL latency: op_valid=%0b op_slot=%0d at 3rd cen, want 1 0", op_valid, op_slot);
        end
      end
      if (sb.size() != 0) begin
        e = sb.pop_front(); checks++;
        if (op_slot !== e.slot || op_phase !== e.ph) begin
          errors++;
          $display("FAIL reset_run op: slot=%0d ph=%0d, want slot=%0d ph=%0d", op_slot, op_phase, e.slot, e.ph);
        end
      end
    end
  endtask

  task automatic test_phase_growth();
    exp_t e;
    int k3 = 0;
    rst_n = 1'b0;
    tbl_blk[3] = 3'd4;  tbl_fnum[3] = 10'h200;  tbl_mul[3] = 4'd1;
    tbl_blk[10] = 3'd7; tbl_fnum[10] = 10'h3ff; tbl_mul[10] = 4'd15;
    apply_reset();
    for (int i = 0; i < 10 * SLOTS; i++) begin
      cyc(1'b1, 1'b0, 5'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front(); checks++;
        if (op_valid !== 1'b1 || op_slot !== e.slot || op_phase !== e.ph) begin
          errors++;
          $display("FAIL growth op: v=%0b slot=%0d ph=%0d, want slot=%0d ph=%0d",
                   op_valid, op_slot, op_phase, e.slot, e.ph);
        end
        if (e.slot == 5'd3) begin
          k3++;
          if (k3 == 10) begin
            checks++;
            if (op_phase !== 10'd40) begin
              errors++;
              $display("FAIL growth slot3 frame10: op_phase=%0d, want 40", op_phase);
            end
          end
        end
      end
      checks++;
      if (obs_rst !== 1'b0) begin
        errors++;
        $display("FAIL growth pg_rst: got %0b want 0", obs_rst);
      end
    end
  endtask

  task automatic test_keyon_pending();
    exp_t e;
    int nrst = 0, rslot = -1, n3 = 0;
    logic [9:0] r3 [2];
    r3[0] = '1; r3[1] = '1;
    for (int i = 0; i < 4 * SLOTS + 2; i++) begin
      if (((m_n - 2) % SLOTS) == 7) begin
        cyc(1'b1, 1'b1, 5'd3);
        break;
      end
      cyc(1'b1, 1'b0, 5'd0);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    for (int i = 0; i < 2 * SLOTS + 1; i++) begin
      if (i > 0) cyc(1'b1, 1'b0, 5'd0);
      if (obs_rst === 1'b1) begin nrst++; rslot = cur_s2; end
      checks++;
      if (obs_rst !== exp_rst) begin
        errors++;
        $display("FAIL keyon_pend pg_rst slot%0d: got %0b want %0b", cur_s2, obs_rst, exp_rst);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front(); checks++;
        if (op_valid !== 1'b1 || op_slot !== e.slot || op_phase !== e.ph) begin
          errors++;
          $display("FAIL keyon_pend op: slot=%0d ph=%0d, want slot=%0d ph=%0d", op_slot, op_phase, e.slot, e.ph);
        end
        if (op_slot === 5'd3 && n3 < 2) begin r3[n3] = op_phase; n3++; end
      end
    end
    checks++;
    if (nrst != 1 || rslot != 3) begin
      errors++;
      $display("FAIL keyon_pend count: resets=%0d slot=%0d, want 1 at slot 3", nrst, rslot);
    end
    checks++;
    if (r3[0] !== 10'd0 || r3[1] !== 10'd4) begin
      errors++;
      $display("FAIL keyon_pend slot3 phases: %0d,%0d want 0,4", r3[0], r3[1]);
    end
  endtask

  task automatic test_keyon_same();
    exp_t e;
    int nrst;
    for (int i = 0; i < 2 * SLOTS; i++) begin
      if (((m_n - 2) % SLOTS) == 5) break;
      cyc(1'b1, 1'b0, 5'd0);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    cyc(1'b1, 1'b1, 5'd5);
    if (sb.size() != 0) void'(sb.pop_front());
    checks++;
    if (obs_rst !== 1'b1 || cur_s2 != 5) begin
      errors++;
      $display("FAIL keyon_same immediate: pg_rst=%0b (stage2 slot %0d), want 1 at 5", obs_rst, cur_s2);
    end
    // Three sub-phases: no repeat for slot 5, out-of-range slot ignored, merged requests.
    for (int ph = 0; ph < 3; ph++) begin
      nrst = 0;
      if (ph == 1) cyc(1'b1, 1'b1, 5'd20);
      if (ph == 2) begin
        for (int i = 0; i < 2 * SLOTS; i++) begin
          if (((m_n - 2) % SLOTS) == 8) break;
          cyc(1'b1, 1'b0, 5'd0);
          if (sb.size() != 0) void'(sb.pop_front());
        end
        cyc(1'b1, 1'b1, 5'd3);
        if (sb.size() != 0) void'(sb.pop_front());
        cyc(1'b1, 1'b1, 5'd3);
      end
      if (sb.size() != 0) void'(sb.pop_front());
      for (int i = 0; i < 2 * SLOTS; i++) begin
        cyc(1'b1, 1'b0, 5'd0);
        if (obs_rst === 1'b1) nrst++;
        if (sb.size() != 0) begin
          e = sb.pop_front(); checks++;
          if (op_slot !== e.slot || op_phase !== e.ph) begin
            errors++;
            $display("FAIL keyon_same op ph%0d: slot=%0d ph=%0d, want slot=%0d ph=%0d",
                     ph, op_slot, op_phase, e.slot, e.ph);
          end
        end
      end
      checks++;
      if (nrst != ((ph == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL keyon_same resets ph%0d: got %0d want %0d", ph, nrst, (ph == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_cen_toggle();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 3 * (SLOTS + 6); i++) begin
      cyc(i % 3 == 0, (i == 4), 5'd3);
      checks++;
      if (cfg_slot !== 5'(m_n % SLOTS) || zero !== exp_zero || op_valid !== exp_valid) begin
        errors++;
        $display("FAIL cen_toggle cyc%0d: cfg_slot=%0d zero=%0b op_valid=%0b, want %0d %0b %0b",
                 i, cfg_slot, zero, op_valid, m_n % SLOTS, exp_zero, exp_valid);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front(); checks++;
        if (op_slot !== e.slot || op_phase !== e.ph || obs_rst !== exp_rst) begin
          errors++;
          $display("FAIL cen_toggle op: slot=%0d ph=%0d rst=%0b, want slot=%0d ph=%0d rst=%0b",
                   op_slot, op_phase, obs_rst, e.slot, e.ph, exp_rst);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int i = 0; i < 2 * SLOTS; i++) begin
      if ((m_n % SLOTS) == 11) break;
      cyc(1'b1, 1'b0, 5'd0);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_slot, pg_block, pg_fnum, pg_mul, pg_phinc_in, pg_phase_in, pg_rst,
         op_slot, op_phase, op_valid, zero} !== '0) begin
      errors++;
      $display("FAIL reset_mid async: cfg_slot=%0d op_valid=%0b op_slot=%0d op_phase=%0d pg_phase_in=%0h, want all 0",
               cfg_slot, op_valid, op_slot, op_phase, pg_phase_in);
    end
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < SLOTS + 4; i++) begin
      cyc(1'b1, 1'b0, 5'd0);
      checks++;
      if (cfg_slot !== 5'(m_n % SLOTS) || op_valid !== exp_valid) begin
        errors++;
        $display("FAIL reset_mid restart cen%0d: cfg_slot=%0d op_valid=%0b, want %0d %0b",
                 i + 1, cfg_slot, op_valid, m_n % SLOTS, exp_valid);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front(); checks++;
        if (op_slot !== e.slot || op_phase !== e.ph) begin
          errors++;
          $display("FAIL reset_mid op: slot=%0d ph=%0d, want slot=%0d ph=%0d", op_slot, op_phase, e.slot, e.ph);
        end
        if (e.slot == 5'd3) begin
          checks++;
          if (op_phase !== 10'd4) begin
            errors++;
            $display("FAIL reset_mid slot3 first frame: op_phase=%0d want 4", op_phase);
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < SLOTS; i++) begin
      tbl_blk[i] = '0; tbl_fnum[i] = '0; tbl_mul[i] = '0;
    end
    rst_n = 1'b0; cen = 1'b0; keyon_req = 1'b0; keyon_slot = 5'd0;
    model_clear();
    test_reset();
    test_phase_growth();
    test_keyon_pending();
    test_keyon_same();
    test_cen_toggle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
